// File: rtl/lsu.sv
// Load/store unit: byte-addressed loads/stores onto a single-port word memory,
// read-modify-write for sub-word stores. Optional FEATHER_LSU_ALIGN_CHECK_EN rejects misaligned accesses.
module lsu #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o,
    output logic [31:0] mem_address_o,
    output logic        mem_write_enable_o,
    output logic [31:0] mem_write_data_o,
    input  logic [31:0] mem_data_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [30:0] WORD_LIMIT = 31'(MEM_WORDS);

    logic [1:0]  state;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_wdata;
    logic [31:0] result;
    logic [31:0] merged;
    logic        err_flag;

    logic        req_error;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] store_merged;

    always_comb begin
        req_error = 1'b0;
        if (req_size_i == 2'b11) begin
            req_error = 1'b1;
        end
        if ({1'b0, req_addr_i[31:2]} >= WORD_LIMIT) begin
            req_error = 1'b1;
        end
`ifdef FEATHER_LSU_ALIGN_CHECK_EN
        if (req_size_i == SIZE_HALF && req_addr_i[0]) begin
            req_error = 1'b1;
        end
        if (req_size_i == SIZE_WORD && req_addr_i[1:0] != 2'b00) begin
            req_error = 1'b1;
        end
`else
        // Misaligned accesses fall through; the lane logic ignores the low address bits it does not use.
`endif
    end

    // Little-endian lane pick from the word currently presented by memory.
    always_comb begin
        byte_lane = 8'h00;
        case (lat_addr[1:0])
            2'd0: byte_lane = mem_data_i[7:0];
            2'd1: byte_lane = mem_data_i[15:8];
            2'd2: byte_lane = mem_data_i[23:16];
            2'd3: byte_lane = mem_data_i[31:24];
            default: byte_lane = 8'h00;
        endcase
        half_lane = lat_addr[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    end

    always_comb begin
        load_ext = mem_data_i;
        case (lat_size)
            SIZE_BYTE: load_ext = lat_unsigned ? {24'h000000, byte_lane}
                                               : {{24{byte_lane[7]}}, byte_lane};
            SIZE_HALF: load_ext = lat_unsigned ? {16'h0000, half_lane}
                                               : {{16{half_lane[15]}}, half_lane};
            default:   load_ext = mem_data_i;
        endcase
    end

    always_comb begin
        store_merged = mem_data_i;
        case (lat_size)
            SIZE_BYTE: begin
                case (lat_addr[1:0])
                    2'd0: store_merged[7:0]   = lat_wdata[7:0];
                    2'd1: store_merged[15:8]  = lat_wdata[7:0];
                    2'd2: store_merged[23:16] = lat_wdata[7:0];
                    2'd3: store_merged[31:24] = lat_wdata[7:0];
                    default: store_merged = mem_data_i;
                endcase
            end
            SIZE_HALF: begin
                if (lat_addr[1]) begin
                    store_merged[31:16] = lat_wdata[15:0];
                end else begin
                    store_merged[15:0] = lat_wdata[15:0];
                end
            end
            default: store_merged = lat_wdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat_write    <= 1'b0;
            lat_addr     <= 32'h0;
            lat_size     <= SIZE_BYTE;
            lat_unsigned <= 1'b0;
            lat_wdata    <= 32'h0;
            result       <= 32'h0;
            merged       <= 32'h0;
            err_flag     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        lat_write    <= req_write_i;
                        lat_addr     <= req_addr_i;
                        lat_size     <= req_size_i;
                        lat_unsigned <= req_unsigned_i;
                        lat_wdata    <= req_wdata_i;
                        result       <= 32'h0;
                        err_flag     <= req_error;
                        state        <= req_error ? RESP : READ;
                    end
                end
                READ: begin
                    if (lat_write) begin
                        merged <= store_merged;
                        state  <= WRITE;
                    end else begin
                        result <= load_ext;
                        state  <= RESP;
                    end
                end
                WRITE: state <= RESP;
                RESP:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Response data is only meaningful for a successful load.
    assign req_ready_o        = (state == IDLE);
    assign resp_valid_o       = (state == RESP);
    assign resp_error_o       = (state == RESP) && err_flag;
    assign resp_rdata_o       = ((state == RESP) && !err_flag && !lat_write) ? result : 32'h0;
    assign mem_address_o      = {2'b00, lat_addr[31:2]};
    assign mem_write_enable_o = (state == WRITE);
    assign mem_write_data_o   = merged;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a 256-word behavioural memory.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_data;

   logic [31:0] mem [0:255];
   logic        tb_we;
   logic [7:0]  tb_idx;
   logic [31:0] tb_data;
   int          strobes = 0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] r_data;
   logic        r_err;
   int          r_lat;
   int          r_wcyc;
   int          r_wcnt;
   int          s0;

   always #5 clk = ~clk;

   lsu #(.MEM_WORDS(256)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req_valid_i        (req_valid),
      .req_ready_o        (req_ready),
      .req_write_i        (req_write),
      .req_addr_i         (req_addr),
      .req_size_i         (req_size),
      .req_unsigned_i     (req_unsigned),
      .req_wdata_i        (req_wdata),
      .resp_valid_o       (resp_valid),
      .resp_rdata_o       (resp_rdata),
      .resp_error_o       (resp_error),
      .mem_address_o      (mem_addr),
      .mem_write_enable_o (mem_we),
      .mem_write_data_o   (mem_wdata),
      .mem_data_i         (mem_data)
   );

   assign mem_data = mem[mem_addr[7:0]];

   // Behavioural memory: DUT write strobe has priority over bench preloads.
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
         strobes <= strobes + 1;
      end else if (tb_we) begin
         mem[tb_idx] <= tb_data;
      end
   end

   // Compares one observed value against its expectation and counts failures.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Writes one memory word through the bench port.
   task automatic preload(input logic [7:0] idx, input logic [31:0] d);
      @(negedge clk);
      tb_we   = 1'b1;
      tb_idx  = idx;
      tb_data = d;
      @(negedge clk);
      tb_we   = 1'b0;
   endtask

   // Issues one request and waits (bounded) for its response pulse.
   task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [1:0] sz,
                                input logic u, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er,
                                output int lat, output int wcyc, output int wcnt);
      int start;
      rd   = 32'hxxxxxxxx;
      er   = 1'bx;
      lat  = 0;
      wcyc = 0;
      @(negedge clk);
      req_valid    = 1'b1;
      req_write    = w;
      req_addr     = a;
      req_size     = sz;
      req_unsigned = u;
      req_wdata    = wd;
      start        = strobes;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_wdata = 32'h0BAD0BAD;
      req_addr  = 32'hFFFFFFFF;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (mem_we) wcyc = k;
         if (resp_valid) begin
            rd  = resp_rdata;
            er  = resp_error;
            lat = k;
            break;
         end
      end
      if (lat == 0) begin
         n_checks++;
         n_fail++;
         $error("[TB] FAIL timeout: no resp_valid within 10 cycles for addr %0h", a);
      end
      wcnt = strobes - start;
   endtask

   // Main directed sequence.
   initial begin
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_addr     = 32'h0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_wdata    = 32'h0;
      tb_we        = 1'b0;
      tb_idx       = 8'h0;
      tb_data      = 32'h0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;

      #22;
      checkOutput("reset_ready", req_ready, 1'b1);
      checkOutput("reset_resp_valid", resp_valid, 1'b0);
      checkOutput("reset_resp_error", resp_error, 1'b0);
      checkOutput("reset_resp_rdata", resp_rdata, 32'h0);
      checkOutput("reset_mem_we", mem_we, 1'b0);
      checkOutput("reset_mem_addr", mem_addr, 32'h0);
      checkOutput("reset_mem_wdata", mem_wdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, r_data, r_err, r_lat, r_wcyc, r_wcnt);
      checkOutput("sw_error", r_err, 1'b0);
      checkOutput("sw_latency", r_lat, 3);
      checkOutput("sw_strobe_cycle", r_wcyc, 2);
      checkOutput("sw_strobe_count", r_wcnt, 1);
      checkOutput("sw_rdata", r_data, 32'h0);
      checkOutput("sw_mem4", mem[4], 32'hDEADBEEF);
      applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, r_data, r_err, r_lat, r_wcyc, r_wcnt);
      checkOutput("lw_rdata", r_data, 32'hDEADBEEF);
      checkOutput("lw_latency", r_lat, 2);
      checkOutput("lw_error", r_err, 1'b0);
      checkOutput("lw_strobe_count", r_wcnt, 0);

      preload(8'd4, 32'h11223344);
      applyStimulus(1'b1, 32'h11, 2'b00, 1'b0, 32'h123456AA, r_data, r_err, r_lat, r_wcyc, r_wcnt);
      checkOutput("sb_strobe_count", r_wcnt, 1);
      checkOutput("sb_mem4", mem[4], 32'h1122AA44);
      applyStimulus(1'b0, 32'h11, 2'b00, 1'b0, 32'h0, r_data, r_err, r_lat, r_wcyc, r_wcnt);
      checkOutput("lb_signed", r_data, 32'hFFFFFFAA);
      applyStimulus(1'b0, 32'h11, 2'b00, 1'b1, 32'h0, r_data, r_err, r_lat, r_wcyc, r_wcnt);
      checkOutput("lb_unsigned", r_data, 32'h000000AA);
      applyStimulus(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, r_data, r_err, r_lat, r_wcyc, r_wcnt);
      checkOutput("lb_lane3", r_data, 32'h00000011);

      preload(8'd4, 32'h80017FFF);
      applyStimulus(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, r_data, r_err, r_lat, r_wcyc, r_wcnt);
      checkOutput("lh_signed_hi", r_data, 32'hFFFF8001);
      applyStimulus(1'b0, 32'h12, 2'b01, 1'b1, 32'h0, r_data, r_err, r_lat, r_wcyc, r_wcnt);
      checkOutput("lh_unsigned_hi", r_data, 32'h00008001);
      applyStimulus(1'b0, 32'h10, 2'b01, 1'b0, 32'h0, r_data, r_err, r_lat, r_wcyc, r_wcnt);
      checkOutput("lh_signed_lo", r_data, 32'h00007FFF);
      applyStimulus(1'b1, 32'h12, 2'b01, 1'b0, 32'h1234BEEF, r_data, r_err, r_lat, r_wcyc, r_wcnt);
      checkOutput("sh_mem4", mem[4], 32'hBEEF7FFF);

      applyStimulus(1'b0, 32'h400, 2'b10, 1'b0, 32'h0, r_data, r_err, r_lat, r_wcyc, r_wcnt);
      checkOutput("range_latency", r_lat, 1);
      checkOutput("range_error", r_err, 1'b1);
      checkOutput("range_rdata", r_data, 32'h0);
      checkOutput("range_strobe_count", r_wcnt, 0);
      applyStimulus(1'b1, 32'h400, 2'b10, 1'b0, 32'h55AA55AA, r_data, r_err, r_lat, r_wcyc, r_wcnt);
      checkOutput("range_store_error", r_err, 1'b1);
      checkOutput("range_store_strobes", r_wcnt, 0);
      applyStimulus(1'b1, 32'h10, 2'b11, 1'b0, 32'h12345678, r_data, r_err, r_lat, r_wcyc, r_wcnt);
      checkOutput("size11_error", r_err, 1'b1);
      checkOutput("size11_latency", r_lat, 1);
      checkOutput("size11_strobes", r_wcnt, 0);
      checkOutput("size11_mem4", mem[4], 32'hBEEF7FFF);

      preload(8'd255, 32'hA5A50001);
      applyStimulus(1'b0, 32'h3FC, 2'b10, 1'b0, 32'h0, r_data, r_err, r_lat, r_wcyc, r_wcnt);
      checkOutput("top_word_error", r_err, 1'b0);
      checkOutput("top_word_rdata", r_data, 32'hA5A50001);

      preload(8'd4, 32'h11223344);
      applyStimulus(1'b1, 32'h13, 2'b10, 1'b0, 32'hCAFEF00D, r_data, r_err, r_lat, r_wcyc, r_wcnt);
`ifdef FEATHER_LSU_ALIGN_CHECK_EN
      checkOutput("misaligned_sw_error", r_err, 1'b1);
      checkOutput("misaligned_sw_strobes", r_wcnt, 0);
      checkOutput("misaligned_sw_mem4", mem[4], 32'h11223344);
      applyStimulus(1'b0, 32'h11, 2'b01, 1'b1, 32'h0, r_data, r_err, r_lat, r_wcyc, r_wcnt);
      checkOutput("misaligned_lh_error", r_err, 1'b1);
      checkOutput("misaligned_lh_rdata", r_data, 32'h0);
`else
      checkOutput("misaligned_sw_error", r_err, 1'b0);
      checkOutput("misaligned_sw_strobes", r_wcnt, 1);
      checkOutput("misaligned_sw_mem4", mem[4], 32'hCAFEF00D);
      applyStimulus(1'b0, 32'h11, 2'b01, 1'b1, 32'h0, r_data, r_err, r_lat, r_wcyc, r_wcnt);
      checkOutput("misaligned_lh_error", r_err, 1'b0);
      checkOutput("misaligned_lh_rdata", r_data, 32'h0000F00D);
`endif

      preload(8'd8, 32'h01020304);
      s0 = strobes;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h20;
      req_size  = 2'b10;
      req_wdata = 32'h55555555;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("pre_reset_in_write", mem_we, 1'b1);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_mem_we", mem_we, 1'b0);
      checkOutput("midreset_resp_valid", resp_valid, 1'b0);
      checkOutput("midreset_ready", req_ready, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("midreset_no_strobe", strobes - s0, 0);
      checkOutput("midreset_mem8", mem[8], 32'h01020304);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, r_data, r_err, r_lat, r_wcyc, r_wcnt);
      checkOutput("post_reset_rdata", r_data, 32'h01020304);
      checkOutput("post_reset_latency", r_lat, 2);
      checkOutput("post_reset_error", r_err, 1'b0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the core's execute stage and the single-port word memory. It accepts one byte-addressed load or store at a time over a valid/ready handshake and converts it into word-indexed memory accesses. Sub-word stores use a read-modify-write sequence, and loads return sign- or zero-extended data. Each request produces exactly one single-cycle response pulse.

## Interface
Parameters:
- MEM_WORDS, 256, number of 32-bit words in the attached memory; valid word indices are 0..MEM_WORDS-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  unit can accept; high only in IDLE.
- req_write_i  input  1  1 = store, 0 = load.
- req_addr_i  input  32  byte address.
- req_size_i  input  2  00 byte, 01 halfword, 10 word; 11 is illegal.
- req_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0.
- req_wdata_i  input  32  store data, right-aligned.
- resp_valid_o  output  1  one-cycle response pulse.
- resp_rdata_o  output  32  extended load data; 0 for stores and errors.
- resp_error_o  output  1  request rejected; qualified by resp_valid_o.
- mem_address_o  output  32  word index, equal to req_addr_i[31:2] of the latched request.
- mem_write_enable_o  output  1  memory write strobe.
- mem_write_data_o  output  32  merged word to write.
- mem_data_i  input  32  combinational read data for mem_address_o.

Clock/reset decision: one clock; reset is asynchronous and active-low.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, latch write, addr, size, unsigned and wdata.
  - Check the request. Go to RESP with error if any of: size = 11, word index >= MEM_WORDS, or the alignment check fails (see Configuration). Otherwise go to READ.
- READ:
  - Drive mem_address_o. Sample mem_data_i.
  - Load: extract the lane and extend it into the result register, then go to RESP.
  - Word store: go to WRITE with merged = wdata.
  - Sub-word store: merge wdata[7:0] or wdata[15:0] into the sampled word at the lane, then go to WRITE.
- Lane selection, little-endian:
  - byte = addr[1:0]*8.
  - halfword = addr[1]*16.
- WRITE: mem_write_enable_o = 1 for exactly this cycle, mem_write_data_o = merged, then go to RESP.
- RESP:
  - resp_valid_o = 1.
  - resp_rdata_o = result for loads, 0 for stores and errors.
  - resp_error_o set for error requests.
  - Return to IDLE. There is no backpressure: the consumer must take the response in this cycle.
- mem_write_enable_o is never asserted for a request that errored.
- mem_address_o holds the latched word index in every state; it is 0 after reset.

## Timing
- Request accepted at edge N. Responses appear at:
  - Load: resp_valid_o in cycle N+2.
  - Store: write strobe in cycle N+2, resp_valid_o in cycle N+3.
  - Error: resp_valid_o in cycle N+1.
- Throughput: one request per 3 cycles (load) or 4 cycles (store).
- A new request is accepted in the cycle after RESP at the earliest.
- Reset values:
  - state = IDLE, so req_ready_o = 1.
  - resp_valid_o = 0, resp_error_o = 0, resp_rdata_o = 0.
  - mem_write_enable_o = 0, mem_address_o = 0, mem_write_data_o = 0.
- Reset asserted mid-request: the unit returns to IDLE immediately and asynchronously. A pending write is dropped with no strobe, and no response is issued.
- req_valid_i is ignored outside IDLE. Request fields are only sampled at acceptance.

## Configuration
- FEATHER_LSU_ALIGN_CHECK_EN defined:
  - A halfword with addr[0] = 1 is an error.
  - A word with addr[1:0] != 0 is an error.
- Undefined:
  - Misaligned requests are force-aligned. Halfword uses addr[1] only; word ignores addr[1:0].
  - No alignment error is raised. Size 11 and range errors still apply.

## Test plan
- Word store 0xDEADBEEF to addr 0x10, then word load from 0x10 -> mem word 4 = 0xDEADBEEF; load resp_rdata 0xDEADBEEF at N+2, error 0.
- Byte store 0xAA to 0x11 over word 0x11223344 -> single write strobe, word = 0x1122AA44. Signed byte load from 0x11 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- Halfword load from 0x12 of word 0x80017FFF, signed -> 0xFFFF8001; unsigned -> 0x00008001.
- Word load from addr 0x400 (MEM_WORDS = 256) -> resp_valid at N+1, error 1, rdata 0, no write strobe. Word store to 0x13:
  - With FEATHER_LSU_ALIGN_CHECK_EN: error 1.
  - Without it: writes word 4, error 0.
- Assert rst_n low during WRITE of a store -> write strobe and resp_valid stay 0, req_ready_o = 1, memory word unchanged. Next request completes normally.
